vga_board_renderer: RTL and testbench
=====================================

Name: vga_board_renderer

Overview:
- Parametrised successor to the sea-battle VGA display.
- Generates VGA timing and renders two GRID_N x GRID_N boards plus a cursor.
- Reads per-cell state from an external board memory through a 1-cycle-latency read port.
- 2-stage pixel pipeline with syncs delayed to match colour; cursor blinks at a frame-based rate; one-cycle frame-start pulse for the game FSM.

Parameters:
H_DISPLAY 640 active pixels per line
H_FRONT 16 / H_SYNC 96 / H_BACK 48 horizontal porch and sync widths, clocks
V_DISPLAY 480 active lines
V_FRONT 10 / V_SYNC 2 / V_BACK 33 vertical porch and sync widths, lines
GRID_N 10 cells per board side (2..15)
CELL_SIZE 30 cell pitch, pixels
GRID0_X 20 / GRID1_X 330 / GRID_Y 50 board top-left origins
BLINK_FRAMES 30 frames per cursor blink half-period
COLOR_W 4 colour channel width (>=4)

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
cursor_grid  in  1  board holding the cursor (0 = own, 1 = enemy)
cursor_row  in  4  cursor row, 0..GRID_N-1
cursor_col  in  4  cursor column, 0..GRID_N-1
cell_addr  out  9  {grid, row[3:0], col[3:0]} board-memory read address
cell_data  in  2  cell state, valid exactly 1 clk after cell_addr: 00 empty, 01 ship, 10 hit, 11 miss
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
red/green/blue  out  COLOR_W each  pixel colour
frame_start  out  1  one-cycle pulse coinciding with output of pixel (0,0)

Behaviour:
- Decided interface: one clock (clk); reset asynchronous and active-low (rst_n).
- Reset values: counters 0, cell_addr 0, hsync=1, vsync=1, RGB=0, frame_start=0, blink phase=on, blink counter 0, latched cursor = invalid (nothing drawn until first frame_start).
- Stage 0 (counters):
  - h counts 0..H_TOTAL-1, H_TOTAL = sum of the four H parameters.
  - v increments on h wrap and counts 0..V_TOTAL-1.
  - Defaults give 800 x 525 = 420000 clk per frame.
- Stage 1 (decode):
  - Compute board membership, cell row/col and in-cell offsets using incremental sub-counters. No divide or modulo hardware.
  - Board extent: origin to origin + GRID_N*CELL_SIZE, inclusive, so a closing border is drawn.
  - Drive cell_addr. When the pixel is outside both boards, cell_addr holds its last value.
- Stage 2 (colour): uses cell_data plus stage-1 decode, delayed 1 clk. All outputs are registered here.
  - Total latency from counter value (h,v) to its RGB/hsync/vsync on the outputs is exactly 2 clk.
  - Syncs are derived from stage-0 counts and delayed 2 clk.
  - hsync low for h in [H_DISPLAY+H_FRONT, +H_SYNC); vsync low likewise on v.
- Colour priority, highest first (values at 4 bits; left-aligned, zero-padded LSBs when COLOR_W>4):
  1. Blanking, i.e. h>=H_DISPLAY or v>=V_DISPLAY -> 0,0,0.
  2. Grid line (in-cell x or y offset 0, or closing border) -> 15,15,15.
  3. Cursor: interior pixel of latched cursor cell on latched grid, with blink phase on -> 15,15,0.
  4. Cell state:
     - hit -> 15,0,0
     - miss -> 4,4,15
     - ship on grid 0 -> 8,8,8
     - ship on grid 1 -> rendered as empty (enemy ships hidden)
     - empty -> grid 0: 0,6,0; grid 1: 6,0,0
  5. Background -> 0,0,8.
- Cursor latch: cursor_grid/row/col are sampled on the cycle the counters wrap to (0,0). They are stable for the whole frame (no tearing). Row or col >= GRID_N -> no cursor drawn that frame.
- Blink: the counter increments at each frame wrap. On reaching BLINK_FRAMES-1 it clears and toggles the phase.
- frame_start: high for exactly one clk per frame, in the same cycle the outputs carry pixel (0,0).
- Reset mid-frame: all state returns to reset values immediately. The first frame after release starts at (0,0), and its first frame_start occurs 2 clk after release.
- Boards must not overlap; if mis-parameterised, grid 1 wins.

Test Plan:
- Reset/timing: hold rst_n=0 for 5 clk, release, run 2 frames -> hsync low 96 clk every 800; vsync low 2 lines (1600 clk) every 525 lines; frame_start period 420000 clk; RGB=0 in all blanking.
- Grid lines: all cell_data=00 -> pixel (20,50) = 15,15,15; (21,51) = 0,6,0; (320,60) = white border; (331,51) = 6,0,0; (10,10) = 0,0,8.
- Memory pipeline: bench models a 1-clk RAM with grid0 r2 c3 = hit -> cell_addr = {0,2,3} while decoding pixel (111,111); output of (111,111) = 15,0,0, appearing 2 clk after h=111,v=111.
- Hidden ships/miss: grid1 r0 c0 = 01 -> (331,51) = 6,0,0; grid0 r0 c0 = 01 -> (21,51) = 8,8,8; miss cell -> 4,4,15.
- Cursor and blink: cursor 1/4/5 -> (481,171) = 15,15,0 for frames 0..29, cell colour for frames 30..59; cursor change mid-frame takes effect only next frame; col=12 -> no cursor.
- Mid-frame reset: assert rst_n=0 at v=200 -> outputs return to reset values within 1 clk; after release the first frame_start occurs 2 clk later and timing matches scenario 1.

Source files
------------

// File: rtl/vga_board_renderer_if.sv
// Signal bundle between the board renderer and its surroundings: cursor inputs,
// board-memory read port and the VGA video outputs.
interface vga_board_renderer_if #(
    parameter int unsigned COLOR_W = 4
) ();
    logic               cursor_grid;
    logic [3:0]         cursor_row;
    logic [3:0]         cursor_col;
    logic [8:0]         cell_addr;
    logic [1:0]         cell_data;
    logic               hsync;
    logic               vsync;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               frame_start;

    modport master (
        input  cursor_grid, cursor_row, cursor_col, cell_data,
        output cell_addr, hsync, vsync, red, green, blue, frame_start
    );

    modport slave (
        output cursor_grid, cursor_row, cursor_col, cell_data,
        input  cell_addr, hsync, vsync, red, green, blue, frame_start
    );
endinterface

// File: rtl/vga_board_renderer.sv
// VGA timing plus two-board renderer: counters -> cell decode / memory read -> colour,
// with syncs delayed to line up with the colour and a per-frame latched, blinking cursor.
module vga_board_renderer #(
    parameter int unsigned H_DISPLAY    = 640,
    parameter int unsigned H_FRONT      = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BACK       = 48,
    parameter int unsigned V_DISPLAY    = 480,
    parameter int unsigned V_FRONT      = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BACK       = 33,
    parameter int unsigned GRID_N       = 10,
    parameter int unsigned CELL_SIZE    = 30,
    parameter int unsigned GRID0_X      = 20,
    parameter int unsigned GRID1_X      = 330,
    parameter int unsigned GRID_Y       = 50,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned COLOR_W      = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    vga_board_renderer_if.master bus
);
    localparam int unsigned HTotal = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW     = $clog2(HTotal + 1);
    localparam int unsigned VW     = $clog2(VTotal + 1);
    localparam int unsigned OW     = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    localparam int unsigned BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned BoardW = GRID_N * CELL_SIZE;

    localparam logic [HW-1:0] HLast     = HW'(HTotal - 1);
    localparam logic [HW-1:0] HDisp     = HW'(H_DISPLAY);
    localparam logic [HW-1:0] HsLo      = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] HsHi      = HW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] X0Lo      = HW'(GRID0_X);
    localparam logic [HW-1:0] X0Hi      = HW'(GRID0_X + BoardW);
    localparam logic [HW-1:0] X1Lo      = HW'(GRID1_X);
    localparam logic [HW-1:0] X1Hi      = HW'(GRID1_X + BoardW);
    localparam logic [VW-1:0] VLast     = VW'(VTotal - 1);
    localparam logic [VW-1:0] VDisp     = VW'(V_DISPLAY);
    localparam logic [VW-1:0] VsLo      = VW'(V_DISPLAY + V_FRONT);
    localparam logic [VW-1:0] VsHi      = VW'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] YLo       = VW'(GRID_Y);
    localparam logic [VW-1:0] YHi       = VW'(GRID_Y + BoardW);
    localparam logic [OW-1:0] OffLast   = OW'(CELL_SIZE - 1);
    localparam logic [BW-1:0] BlinkLast = BW'(BLINK_FRAMES - 1);
    localparam logic [3:0]    GridN     = 4'(GRID_N);

    function automatic logic [COLOR_W-1:0] chan(input logic [3:0] v4);
        return COLOR_W'(v4) << (COLOR_W - 4);
    endfunction

    // Stage 0 state
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [3:0]    x0_col_q, x0_col_d, x1_col_q, x1_col_d, y_row_q, y_row_d;
    logic [OW-1:0] x0_off_q, x0_off_d, x1_off_q, x1_off_d, y_off_q, y_off_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic          cur_grid_q, cur_grid_d, cur_valid_q, cur_valid_d;
    logic [3:0]    cur_row_q, cur_row_d, cur_col_q, cur_col_d;
    logic [8:0]    last_addr_q, last_addr_d;
    logic          h_wrap, frame_wrap, at_origin;

    // Stage 1 state
    logic s1_active_q, s1_active_d, s1_board_q, s1_board_d, s1_grid_q, s1_grid_d;
    logic s1_line_q, s1_line_d, s1_cursor_q, s1_cursor_d;
    logic s1_hsync_q, s1_hsync_d, s1_vsync_q, s1_vsync_d, s1_fs_q, s1_fs_d;

    // Stage 2 state
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               hsync_q, vsync_q, fs_q;

    always_comb begin
        h_wrap     = (h_q == HLast);
        frame_wrap = h_wrap && (v_q == VLast);
        at_origin  = (h_q == '0) && (v_q == '0);
        h_d        = h_wrap ? '0 : h_q + HW'(1);
        v_d        = v_q;
        if (h_wrap) begin
            v_d = frame_wrap ? '0 : v_q + VW'(1);
        end

        // Cell sub-counters track the pixel that h_d/v_d will point at.
        x0_col_d = x0_col_q;
        x0_off_d = x0_off_q;
        if (h_d == X0Lo) begin
            x0_col_d = '0;
            x0_off_d = '0;
        end else if (x0_off_q == OffLast) begin
            x0_off_d = '0;
            x0_col_d = x0_col_q + 4'd1;
        end else begin
            x0_off_d = x0_off_q + OW'(1);
        end

        x1_col_d = x1_col_q;
        x1_off_d = x1_off_q;
        if (h_d == X1Lo) begin
            x1_col_d = '0;
            x1_off_d = '0;
        end else if (x1_off_q == OffLast) begin
            x1_off_d = '0;
            x1_col_d = x1_col_q + 4'd1;
        end else begin
            x1_off_d = x1_off_q + OW'(1);
        end

        y_row_d = y_row_q;
        y_off_d = y_off_q;
        if (h_wrap) begin
            if (v_d == YLo) begin
                y_row_d = '0;
                y_off_d = '0;
            end else if (y_off_q == OffLast) begin
                y_off_d = '0;
                y_row_d = y_row_q + 4'd1;
            end else begin
                y_off_d = y_off_q + OW'(1);
            end
        end

        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_wrap) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        cur_grid_d  = cur_grid_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        cur_valid_d = cur_valid_q;
        if (at_origin) begin
            cur_grid_d  = bus.cursor_grid;
            cur_row_d   = bus.cursor_row;
            cur_col_d   = bus.cursor_col;
            cur_valid_d = (bus.cursor_row < GridN) && (bus.cursor_col < GridN);
        end
    end

    logic       x0_in, x1_in, y_in, in0, in1, board;
    logic [3:0] col;
    logic [OW-1:0] x_off;
    logic [8:0] addr;

    always_comb begin
        x0_in = (h_q >= X0Lo) && (h_q <= X0Hi);
        x1_in = (h_q >= X1Lo) && (h_q <= X1Hi);
        y_in  = (v_q >= YLo) && (v_q <= YHi);
        in1   = x1_in && y_in;
        in0   = x0_in && y_in && !in1;
        board = in0 || in1;
        col   = in1 ? x1_col_q : x0_col_q;
        x_off = in1 ? x1_off_q : x0_off_q;
        addr  = board ? {in1, y_row_q, col} : last_addr_q;
        last_addr_d = addr;

        s1_active_d = (h_q < HDisp) && (v_q < VDisp);
        s1_board_d  = board;
        s1_grid_d   = in1;
        s1_line_d   = (x_off == '0) || (y_off_q == '0);
        // The origin cycle sees the freshly sampled cursor, matching the latch.
        s1_cursor_d = board && !s1_line_d && blink_on_q && (at_origin ?
                      ((bus.cursor_row < GridN) && (bus.cursor_col < GridN) &&
                       (bus.cursor_grid == in1) && (bus.cursor_row == y_row_q) &&
                       (bus.cursor_col == col)) :
                      (cur_valid_q && (cur_grid_q == in1) && (cur_row_q == y_row_q) &&
                       (cur_col_q == col)));
        s1_hsync_d  = !((h_q >= HsLo) && (h_q < HsHi));
        s1_vsync_d  = !((v_q >= VsLo) && (v_q < VsHi));
        s1_fs_d     = at_origin;
    end

    logic [3:0] r4, g4, b4;

    always_comb begin
        r4 = 4'd0;
        g4 = 4'd0;
        b4 = 4'd0;
        if (s1_active_q) begin
            if (s1_board_q && s1_line_q) begin
                {r4, g4, b4} = {4'd15, 4'd15, 4'd15};
            end else if (s1_cursor_q) begin
                {r4, g4, b4} = {4'd15, 4'd15, 4'd0};
            end else if (s1_board_q) begin
                unique case (bus.cell_data)
                    2'b10:   {r4, g4, b4} = {4'd15, 4'd0, 4'd0};
                    2'b11:   {r4, g4, b4} = {4'd4, 4'd4, 4'd15};
                    2'b01:   {r4, g4, b4} = s1_grid_q ? {4'd6, 4'd0, 4'd0} : {4'd8, 4'd8, 4'd8};
                    default: {r4, g4, b4} = s1_grid_q ? {4'd6, 4'd0, 4'd0} : {4'd0, 4'd6, 4'd0};
                endcase
            end else begin
                {r4, g4, b4} = {4'd0, 4'd0, 4'd8};
            end
        end
        red_d   = chan(r4);
        green_d = chan(g4);
        blue_d  = chan(b4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q         <= '0;
            v_q         <= '0;
            x0_col_q    <= '0;
            x0_off_q    <= '0;
            x1_col_q    <= '0;
            x1_off_q    <= '0;
            y_row_q     <= '0;
            y_off_q     <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            cur_grid_q  <= 1'b0;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
            cur_valid_q <= 1'b0;
            last_addr_q <= '0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            x0_col_q    <= x0_col_d;
            x0_off_q    <= x0_off_d;
            x1_col_q    <= x1_col_d;
            x1_off_q    <= x1_off_d;
            y_row_q     <= y_row_d;
            y_off_q     <= y_off_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            cur_grid_q  <= cur_grid_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            cur_valid_q <= cur_valid_d;
            last_addr_q <= last_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_active_q <= 1'b0;
            s1_board_q  <= 1'b0;
            s1_grid_q   <= 1'b0;
            s1_line_q   <= 1'b0;
            s1_cursor_q <= 1'b0;
            s1_hsync_q  <= 1'b1;
            s1_vsync_q  <= 1'b1;
            s1_fs_q     <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            fs_q        <= 1'b0;
        end else begin
            s1_active_q <= s1_active_d;
            s1_board_q  <= s1_board_d;
            s1_grid_q   <= s1_grid_d;
            s1_line_q   <= s1_line_d;
            s1_cursor_q <= s1_cursor_d;
            s1_hsync_q  <= s1_hsync_d;
            s1_vsync_q  <= s1_vsync_d;
            s1_fs_q     <= s1_fs_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hsync_q     <= s1_hsync_q;
            vsync_q     <= s1_vsync_q;
            fs_q        <= s1_fs_q;
        end
    end

    assign bus.cell_addr   = addr;
    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_board_renderer.sv
// Bench for vga_board_renderer on a shrunken raster: every output pixel and every memory
// address is compared with a divide/modulo reference model over randomized boards and cursors.
module tb_vga_board_renderer;
    localparam int unsigned HD = 60, HF = 4, HS = 8, HB = 4;
    localparam int unsigned VD = 32, VF = 2, VS = 2, VB = 3;
    localparam int unsigned N = 4, CS = 6, G0X = 2, G1X = 30, GY = 3, BF = 3, CW = 6;
    localparam int unsigned HT = HD + HF + HS + HB;
    localparam int unsigned VT = VD + VF + VS + VB;
    localparam int unsigned FT = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] mem [512];

    int n_checks = 0;
    int n_fail = 0;
    int n = 0;
    int m_grid, m_row, m_col;
    logic [8:0] m_addr;

    vga_board_renderer_if #(.COLOR_W(CW)) bus ();

    vga_board_renderer #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .GRID_N(N), .CELL_SIZE(CS), .GRID0_X(G0X), .GRID1_X(G1X), .GRID_Y(GY),
        .BLINK_FRAMES(BF), .COLOR_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // External board memory with one clock of read latency
    always @(posedge clk) bus.cell_data <= mem[bus.cell_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [CW-1:0] sc(input int v4);
        return CW'(v4 * (1 << (CW - 4)));
    endfunction

    function automatic void locate(input int h, input int v, output bit in_b, output int g,
                                   output int row, output int col, output bit line);
        int dx, dy;
        in_b = 0; g = 0; row = 0; col = 0; line = 0; dx = 0;
        if (v < GY || v > GY + N * CS) return;
        dy = v - GY;
        if (h >= G1X && h <= G1X + N * CS) begin
            g = 1; dx = h - G1X;
        end else if (h >= G0X && h <= G0X + N * CS) begin
            g = 0; dx = h - G0X;
        end else begin
            return;
        end
        in_b = 1;
        row  = dy / CS;
        col  = dx / CS;
        line = (dx % CS == 0) || (dy % CS == 0);
    endfunction

    function automatic logic [3*CW-1:0] exp_rgb(input int h, input int v, input int f);
        bit in_b, line;
        int g, row, col, r, gr, b;
        bit cur_on;
        if (h >= HD || v >= VD) return '0;
        locate(h, v, in_b, g, row, col, line);
        cur_on = (m_row < N) && (m_col < N) && (m_grid == g) && (m_row == row) &&
                 (m_col == col) && ((f / BF) % 2 == 0);
        if (!in_b) begin
            r = 0; gr = 0; b = 8;
        end else if (line) begin
            r = 15; gr = 15; b = 15;
        end else if (cur_on) begin
            r = 15; gr = 15; b = 0;
        end else begin
            case (mem[g * 256 + row * 16 + col])
                2'b10:   begin r = 15; gr = 0; b = 0; end
                2'b11:   begin r = 4; gr = 4; b = 15; end
                2'b01:   if (g == 1) begin r = 6; gr = 0; b = 0; end
                         else begin r = 8; gr = 8; b = 8; end
                default: if (g == 1) begin r = 6; gr = 0; b = 0; end
                         else begin r = 0; gr = 6; b = 0; end
            endcase
        end
        return {sc(r), sc(gr), sc(b)};
    endfunction

    // Sample one output pixel (index n since reset release) and the address being read now.
    task automatic step();
        int h, v, f, h2, v2, g, row, col;
        bit in_b, line, hs, vs, fs;
        @(negedge clk);
        h = n % HT;
        v = (n / HT) % VT;
        f = n / FT;
        if (h == 0 && v == 0) begin
            m_grid = int'(bus.cursor_grid);
            m_row  = int'(bus.cursor_row);
            m_col  = int'(bus.cursor_col);
        end
        hs = !(h >= HD + HF && h < HD + HF + HS);
        vs = !(v >= VD + VF && v < VD + VF + VS);
        fs = (h == 0 && v == 0);
        check($sformatf("pixel f%0d (%0d,%0d) rgb/hs/vs/fs", f, h, v),
              {bus.red, bus.green, bus.blue, bus.hsync, bus.vsync, bus.frame_start},
              {exp_rgb(h, v, f), hs, vs, fs});
        h2 = (n + 2) % HT;
        v2 = ((n + 2) / HT) % VT;
        locate(h2, v2, in_b, g, row, col, line);
        if (in_b) m_addr = {g[0], row[3:0], col[3:0]};
        check($sformatf("cell_addr (%0d,%0d)", h2, v2), bus.cell_addr, m_addr);
        n++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic check_reset(input string tag);
        check({tag, " rgb"}, {bus.red, bus.green, bus.blue}, '0);
        check({tag, " hs/vs/fs"}, {bus.hsync, bus.vsync, bus.frame_start}, 3'b110);
        check({tag, " cell_addr"}, bus.cell_addr, 9'd0);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 512; i++) mem[i] = 2'($urandom_range(0, 3));
        mem[{1'b0, 4'd2, 4'd3}] = 2'b10;
        mem[{1'b1, 4'd0, 4'd0}] = 2'b01;
        mem[{1'b0, 4'd0, 4'd0}] = 2'b01;
        mem[{1'b0, 4'd1, 4'd1}] = 2'b11;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        m_addr = '0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic rand_cursor();
        bus.cursor_grid = 1'($urandom_range(0, 1));
        bus.cursor_row  = 4'($urandom_range(0, N - 1));
        bus.cursor_col  = 4'($urandom_range(0, N - 1));
    endtask

    initial begin
        bus.cursor_grid = 1'b1;
        bus.cursor_row  = 4'd1;
        bus.cursor_col  = 4'd2;
        fill_mem();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        release_reset();

        run(FT / 2);
        rand_cursor();                  // mid-frame change: visible from frame 1 only
        run(FT);
        bus.cursor_col = 4'd12;         // frame 2 has no cursor
        run(FT);
        rand_cursor();
        run(4 * FT + FT / 2);           // frames 3..5 blink off, frame 6 on

        run(20 * HT);                   // into frame 7, row 20
        rst_n = 1'b0;
        #1 check_reset("midframe reset");
        repeat (3) @(posedge clk);
        fill_mem();
        rand_cursor();
        @(negedge clk);
        check_reset("held reset");
        release_reset();
        run(2 * FT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
